// File: rtl/rpn_pkg.sv
// Shared RPN calculator definitions: opcodes, error codes and sequencer state encoding.
// Used by the token decoder, ALU, printer and rpn_exec_sequencer.
package rpn_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_DIV     = 4'd3;
  localparam logic [3:0] OP_POP     = 4'd4;
  localparam logic [3:0] OP_UNKNOWN = 4'hf;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_DIV0      = 3'd3;
  localparam logic [2:0] ERR_BADOP     = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PUSH  = 4'd1,
    ST_POP_B = 4'd2,
    ST_POP_A = 4'd3,
    ST_EXEC  = 4'd4,
    ST_WAIT  = 4'd5,
    ST_WB    = 4'd6,
    ST_PRINT = 4'd7,
    ST_ERR   = 4'd8
  } seq_state_e;

endpackage

// File: rtl/rpn_exec_sequencer.sv
// Token sequencer: drives the external operand stack, the multi-cycle ALU and the answer printer.
// Build option RPN_AUTO_PRINT_EN: every ALU result is also sent to the printer after write-back.
module rpn_exec_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic               tok_is_num,
  input  logic [WIDTH-1:0]   tok_num,
  input  logic [3:0]         tok_op,
  input  logic [WIDTH-1:0]   stk_top,
  input  logic [DEPTH_W-1:0] stk_depth,
  output logic               stk_push,
  output logic [WIDTH-1:0]   stk_wdata,
  output logic               stk_pop,
  output logic               alu_start,
  output logic [1:0]         alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic               alu_done,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_err,
  output logic               ans_valid,
  output logic [WIDTH-1:0]   ans_data,
  input  logic               ans_ready,
  output logic               err_valid,
  output logic [2:0]         err_code
);

  seq_state_e       state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic             tok_ready_q, stk_push_q, stk_pop_q, alu_start_q, ans_valid_q, err_valid_q;
  logic [WIDTH-1:0] stk_wdata_q, alu_a_q, alu_b_q, ans_data_q;
  logic [1:0]       alu_op_q;
  logic [2:0]       err_code_q;

  logic stk_full, stk_has1, stk_has2;
  assign stk_full = (stk_depth >= DEPTH_W'(DEPTH));
  assign stk_has1 = (stk_depth != '0);
  assign stk_has2 = (stk_depth >= DEPTH_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      b_q         <= '0;
      tok_ready_q <= 1'b1;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      alu_start_q <= 1'b0;
      ans_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      stk_wdata_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      ans_data_q  <= '0;
      alu_op_q    <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      // Pulses last one cycle unless the state below re-asserts them.
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      alu_start_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      case (state_q)
        ST_IDLE: begin
          if (tok_valid) begin
            tok_ready_q <= 1'b0;
            op_q        <= tok_op;
            if (tok_is_num) begin
              if (stk_full) begin
                state_q     <= ST_ERR;
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_OVERFLOW;
              end else begin
                state_q     <= ST_PUSH;
                stk_push_q  <= 1'b1;
                stk_wdata_q <= tok_num;
              end
            end else begin
              case (tok_op)
                OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_POP: begin
                  if ((tok_op == OP_POP) ? !stk_has1 : !stk_has2) begin
                    state_q     <= ST_ERR;
                    err_valid_q <= 1'b1;
                    err_code_q  <= ERR_UNDERFLOW;
                  end else begin
                    state_q   <= ST_POP_B;
                    stk_pop_q <= 1'b1;
                  end
                end
                default: begin
                  state_q     <= ST_ERR;
                  err_valid_q <= 1'b1;
                  err_code_q  <= ERR_BADOP;
                end
              endcase
            end
          end
        end
        ST_POP_B: begin
          b_q <= stk_top;
          if (op_q == OP_POP) begin
            state_q     <= ST_PRINT;
            ans_valid_q <= 1'b1;
            ans_data_q  <= stk_top;
          end else begin
            state_q   <= ST_POP_A;
            stk_pop_q <= 1'b1;
          end
        end
        ST_POP_A: begin
          // stk_top already reflects the first pop, so it is now operand a.
          state_q     <= ST_EXEC;
          alu_start_q <= 1'b1;
          alu_op_q    <= op_q[1:0];
          alu_a_q     <= stk_top;
          alu_b_q     <= b_q;
        end
        ST_EXEC: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              state_q     <= ST_ERR;
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_DIV0;
            end else begin
              state_q     <= ST_WB;
              stk_push_q  <= 1'b1;
              stk_wdata_q <= alu_result;
            end
          end
        end
        ST_WB: begin
`ifdef RPN_AUTO_PRINT_EN
          state_q     <= ST_PRINT;
          ans_valid_q <= 1'b1;
          ans_data_q  <= stk_wdata_q;
`else
          state_q     <= ST_IDLE;
          tok_ready_q <= 1'b1;
`endif
        end
        ST_PRINT: begin
          if (ans_ready) begin
            state_q     <= ST_IDLE;
            ans_valid_q <= 1'b0;
            tok_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          tok_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign tok_ready = tok_ready_q;
  assign stk_push  = stk_push_q;
  assign stk_wdata = stk_wdata_q;
  assign stk_pop   = stk_pop_q;
  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign ans_valid = ans_valid_q;
  assign ans_data  = ans_data_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule
